result_uart_tx: RTL and testbench

- Downstream stage of the neural-network accumulator. Captures the 24-bit result word when the trigger pulse arrives.
- Serialises the word over a UART TX line as 3 bytes, MSB byte first, so the host can read the network output alongside the captured power trace.
- Single clock domain. No DSP use required; all arithmetic is counters and compares.

---
 rtl/result_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_result_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: captures a 24-bit result word on a trigger pulse and
// serialises it as 8N1 UART frames, MSB byte first.
// Optional build macro RESULT_UART_TX_CHECKSUM_EN appends a 4th frame
// carrying the XOR of the three data bytes.
module result_uart_tx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int IDLE_GAP_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigIn,
  input  logic [23:0] dataIn,
  output logic        txOut,
  output logic        busy,
  output logic        txDone,
  output logic [7:0]  dropCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] GAP_LAST  = 16'((IDLE_GAP_BITS > 0) ? IDLE_GAP_BITS - 1 : 0);
`ifdef RESULT_UART_TX_CHECKSUM_EN
  localparam logic [1:0]  LAST_BYTE = 2'd3;
`else
  localparam logic [1:0]  LAST_BYTE = 2'd2;
`endif

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] gap_q, gap_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  drop_q, drop_d;

  logic [7:0]  cur_byte;
  logic        baud_wrap;
  logic        frame_end;

  assign baud_wrap = (baud_q == BAUD_LAST);

  // Select the byte currently on the wire from the latched word.
  always_comb begin
    cur_byte = word_q[7:0];
    case (byte_q)
      2'd0:    cur_byte = word_q[23:16];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[7:0];
`ifdef RESULT_UART_TX_CHECKSUM_EN
      default: cur_byte = word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
`else
      default: cur_byte = word_q[7:0];
`endif
    endcase
  end

  // Next-state, bit timing, line level and drop counting.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    word_d    = word_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
    frame_end = 1'b0;

    // Triggers outside IDLE never touch the word in flight, only the count.
    if (trigIn && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    if (state_q != S_IDLE)
      baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (trigIn) begin
          word_d  = dataIn;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          gap_d   = 16'd0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (IDLE_GAP_BITS > 0) begin
            state_d = S_GAP;
            gap_d   = 16'd0;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (baud_wrap) begin
          if (gap_q == GAP_LAST) frame_end = 1'b1;
          else                   gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // End of a frame: either start the next byte or finish the word.
    if (frame_end) begin
      if (byte_q != LAST_BYTE) begin
        byte_d  = byte_q + 2'd1;
        state_d = S_START;
        tx_d    = 1'b0;
      end else begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // State register with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      gap_q   <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      word_q  <= 24'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign txOut   = tx_q;
  assign busy    = busy_q;
  assign txDone  = done_q;
  assign dropCnt = drop_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: two instances (no gap / 2-bit gap), random words
// and trigger injections checked against a cycle-level line waveform model.
module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_UART_TX_CHECKSUM_EN
  localparam int NFR = 4;
`else
  localparam int NFR = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trig_a, trig_b;
  logic [23:0] data_a, data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  drop_a, drop_b;

  int n_chk  = 0;
  int n_fail = 0;
  int drop_exp[2];

  result_uart_tx #(.CLKS_PER_BIT(CPB), .IDLE_GAP_BITS(0)) u_dut_a (
    .clk(clk), .rst(rst), .trigIn(trig_a), .dataIn(data_a),
    .txOut(tx_a), .busy(busy_a), .txDone(done_a), .dropCnt(drop_a)
  );

  result_uart_tx #(.CLKS_PER_BIT(CPB), .IDLE_GAP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .trigIn(trig_b), .dataIn(data_b),
    .txOut(tx_b), .busy(busy_b), .txDone(done_b), .dropCnt(drop_b)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic t, input logic [23:0] d);
    if (sel == 1) begin trig_b = t; data_b = d; end
    else          begin trig_a = t; data_a = d; end
  endtask

  // Send one word and compare every line cycle against the ideal waveform.
  // start_w: cycles trigIn is held at the start; inj_at/inj_n: extra trigger
  // burst (sample index, length) while busy; tail: check txDone drops again.
  task automatic run_word(input int sel, input logic [23:0] data, input int start_w,
                          input int inj_at, input int inj_n, input bit tail);
    int         gap;
    int         fl;
    int         len;
    int         dsum;
    logic [7:0] bytes[4];
    bit         exp_q[$];
    bit         rec[$];
    logic [7:0] dec;
    logic       tx, bz, dn;
    logic [7:0] dr;
    bit         on;

    gap = (sel == 1) ? 2 : 0;
    fl  = (10 + gap) * CPB;
    len = NFR * fl;
    bytes[0] = data[23:16];
    bytes[1] = data[15:8];
    bytes[2] = data[7:0];
    bytes[3] = data[23:16] ^ data[15:8] ^ data[7:0];
    for (int f = 0; f < NFR; f++) begin
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(bytes[f][i]);
      repeat ((1 + gap) * CPB) exp_q.push_back(1'b1);
    end
    dsum = drop_exp[sel] + (start_w - 1) + inj_n;
    drop_exp[sel] = (dsum > 255) ? 255 : dsum;

    drive(sel, 1'b1, data);
    for (int j = 0; j <= len; j++) begin
      @(negedge clk);
      tx = (sel == 1) ? tx_b   : tx_a;
      bz = (sel == 1) ? busy_b : busy_a;
      dn = (sel == 1) ? done_b : done_a;
      dr = (sel == 1) ? drop_b : drop_a;
      if (j < len) begin
        chk($sformatf("u%0d tx[%0d]", sel, j), tx, exp_q[j]);
        chk($sformatf("u%0d busy[%0d]", sel, j), bz, 1);
        chk($sformatf("u%0d done[%0d]", sel, j), dn, 0);
        rec.push_back(tx);
      end else begin
        chk($sformatf("u%0d done_end", sel), dn, 1);
        chk($sformatf("u%0d busy_end", sel), bz, 0);
        chk($sformatf("u%0d tx_end", sel), tx, 1);
        chk($sformatf("u%0d drop_end", sel), dr, drop_exp[sel]);
      end
      on = (j < start_w - 1) || (inj_n > 0 && j >= inj_at && j < inj_at + inj_n);
      drive(sel, on, 24'($urandom));
    end
    if (tail) begin
      @(negedge clk);
      dn = (sel == 1) ? done_b : done_a;
      tx = (sel == 1) ? tx_b : tx_a;
      chk($sformatf("u%0d done_tail", sel), dn, 0);
      chk($sformatf("u%0d tx_tail", sel), tx, 1);
    end
    // Decode the recorded line at mid-bit like a host UART would.
    for (int f = 0; f < NFR; f++) begin
      for (int i = 0; i < 8; i++) dec[i] = rec[f * fl + (1 + i) * CPB + CPB / 2];
      chk($sformatf("u%0d byte%0d", sel, f), dec, bytes[f]);
    end
  endtask

  initial begin
    int len_a;
    int ia;
    len_a  = NFR * 10 * CPB;
    rst    = 1'b1;
    trig_a = 1'b0; trig_b = 1'b0;
    data_a = 24'd0; data_b = 24'd0;
    drop_exp[0] = 0; drop_exp[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst tx_a", tx_a, 1);     chk("rst busy_a", busy_a, 0);
    chk("rst done_a", done_a, 0); chk("rst drop_a", drop_a, 0);
    chk("rst tx_b", tx_b, 1);     chk("rst busy_b", busy_b, 0);
    chk("rst done_b", done_b, 0); chk("rst drop_b", drop_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic word, then same word with a trigger at cycle 50.
    run_word(0, 24'hA5C30F, 1, -1, 0, 1'b1);
    run_word(0, 24'hA5C30F, 1, 49, 1, 1'b1);
    // Trigger held 3 cycles in IDLE: 2 drops.
    run_word(0, 24'h123456, 3, -1, 0, 1'b1);
    // Long trigger bursts drive dropCnt into saturation.
    repeat (3) run_word(0, 24'($urandom), 1, 5, 110, 1'b1);

    // Reset in the middle of byte 0 data bits.
    drive(0, 1'b1, 24'($urandom));
    @(negedge clk);
    drive(0, 1'b0, 24'd0);
    repeat (23) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", tx_a, 1);
    chk("midrst busy", busy_a, 0);
    chk("midrst drop", drop_a, 0);
    chk("midrst done", done_a, 0);
    drop_exp[0] = 0;
    rst = 1'b0;
    @(negedge clk);
    run_word(0, 24'h000001, 1, -1, 0, 1'b1);

    // Back-to-back: trigger on the returning edge drops, next cycle accepts.
    run_word(0, 24'($urandom), 1, len_a - 1, 1, 1'b0);
    run_word(0, 24'($urandom), 1, -1, 0, 1'b1);

    // Gap instance.
    run_word(1, 24'hFF00FF, 1, -1, 0, 1'b1);
    run_word(1, 24'($urandom), 1, 30, 7, 1'b1);

    // Random words with random trigger bursts.
    repeat (4) begin
      ia = $urandom_range(0, len_a - 1);
      run_word(0, 24'($urandom), $urandom_range(1, 3), ia,
               $urandom_range(1, len_a - ia), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
